// File: rtl/full_adder_reg.sv
// full_adder_reg: registered ripple-carry adder built from 1-bit full-adder
// cells. Returns {cout, sum} = a + b + cin, plus signed overflow and zero
// flags, exactly one clk cycle after the operands are presented.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low
//   in_valid   a/b/cin carry a new operation this cycle
//   a, b       WIDTH-bit operands (unsigned, or two's complement for ovf)
//   cin        carry into bit 0
//   sum        registered (a + b + cin) mod 2^WIDTH
//   cout       registered carry out of the MSB
//   ovf        registered signed overflow (carry into MSB ^ carry out of MSB)
//   zero       registered sum == 0
//   out_valid  registered copy of in_valid
//
// Result registers only load on in_valid, so idle or unknown operands never
// reach the outputs.

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

module full_adder_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             out_valid
);

    // carry[i] is the carry into cell i; carry[WIDTH] leaves the MSB.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .s    (sum_comb[i]),
            .cout (carry[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= sum_comb;
                cout <= carry[WIDTH];
                // For WIDTH=1 carry[WIDTH-1] is cin itself.
                ovf  <= carry[WIDTH-1] ^ carry[WIDTH];
                zero <= (sum_comb == '0);
            end
        end
    end

endmodule

// File: tb/tb_full_adder_reg.sv
module tb_full_adder_reg;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // three instances: WIDTH 1, 8, 16
    logic        v1, c1, v8, c8, v16, c16;
    logic        a1, b1;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;

    logic        s1;
    logic [7:0]  s8;
    logic [15:0] s16;
    logic        co1, ov1, z1, ov_1v;
    logic        co8, ov8, z8, ov_8v;
    logic        co16, ov16, z16, ov_16v;

    full_adder_reg #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
        .sum(s1), .cout(co1), .ovf(ov1), .zero(z1), .out_valid(ov_1v));

    full_adder_reg #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
        .sum(s8), .cout(co8), .ovf(ov8), .zero(z8), .out_valid(ov_8v));

    full_adder_reg #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .a(a16), .b(b16), .cin(c16),
        .sum(s16), .cout(co16), .ovf(ov16), .zero(z16), .out_valid(ov_16v));

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference: plain integer addition for the unsigned result,
    // signed range test for overflow.
    function automatic void ref_add(input int w, input longint unsigned a,
                                    input longint unsigned b, input bit ci,
                                    output longint unsigned s, output bit co,
                                    output bit ov, output bit z);
        longint unsigned full;
        longint sa, sb, rs, half;
        half = longint'(1) << (w - 1);
        full = a + b + longint'(ci);
        s    = full & ((longint'(1) << w) - 1);
        co   = ((full >> w) & 1) != 0;
        sa   = (a >= half) ? longint'(a) - 2 * half : longint'(a);
        sb   = (b >= half) ? longint'(b) - 2 * half : longint'(b);
        rs   = sa + sb + longint'(ci);
        ov   = (rs > half - 1) || (rs < -half);
        z    = (s == 0);
    endfunction

    // model state per instance
    longint unsigned m1_s, m8_s, m16_s;
    bit m1_co, m1_ov, m1_z, m1_v;
    bit m8_co, m8_ov, m8_z, m8_v;
    bit m16_co, m16_ov, m16_z, m16_v;

    always @(posedge clk) begin
        longint unsigned s;
        bit co, ov, z;
        if (!rst_n) begin
            m1_s <= 0;  m1_co <= 0;  m1_ov <= 0;  m1_z <= 0;  m1_v <= 0;
            m8_s <= 0;  m8_co <= 0;  m8_ov <= 0;  m8_z <= 0;  m8_v <= 0;
            m16_s <= 0; m16_co <= 0; m16_ov <= 0; m16_z <= 0; m16_v <= 0;
        end else begin
            m1_v  <= (v1 === 1'b1);
            m8_v  <= (v8 === 1'b1);
            m16_v <= (v16 === 1'b1);
            if (v1 === 1'b1) begin
                ref_add(1, longint'(a1), longint'(b1), c1, s, co, ov, z);
                m1_s <= s; m1_co <= co; m1_ov <= ov; m1_z <= z;
            end
            if (v8 === 1'b1) begin
                ref_add(8, longint'(a8), longint'(b8), c8, s, co, ov, z);
                m8_s <= s; m8_co <= co; m8_ov <= ov; m8_z <= z;
            end
            if (v16 === 1'b1) begin
                ref_add(16, longint'(a16), longint'(b16), c16, s, co, ov, z);
                m16_s <= s; m16_co <= co; m16_ov <= ov; m16_z <= z;
            end
        end
    end

    // compare every cycle once the first reset edge has happened
    always @(negedge clk) begin
        if (chk_en) begin
            check("w1_vld",  longint'(ov_1v), longint'(m1_v));
            check("w1_sum",  longint'(s1),    m1_s);
            check("w1_cout", longint'(co1),   longint'(m1_co));
            check("w1_ovf",  longint'(ov1),   longint'(m1_ov));
            check("w1_zero", longint'(z1),    longint'(m1_z));
            check("w8_vld",  longint'(ov_8v), longint'(m8_v));
            check("w8_sum",  longint'(s8),    m8_s);
            check("w8_cout", longint'(co8),   longint'(m8_co));
            check("w8_ovf",  longint'(ov8),   longint'(m8_ov));
            check("w8_zero", longint'(z8),    longint'(m8_z));
            check("w16_vld",  longint'(ov_16v), longint'(m16_v));
            check("w16_sum",  longint'(s16),    m16_s);
            check("w16_cout", longint'(co16),   longint'(m16_co));
            check("w16_ovf",  longint'(ov16),   longint'(m16_ov));
            check("w16_zero", longint'(z16),    longint'(m16_z));
        end
    end

    initial begin
        logic [1:0] exp_tbl [8];
        exp_tbl = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        rst_n = 1'b0;
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        v8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
        v16 = 1'b0; a16 = '0; b16 = '0; c16 = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;

        // reset held two cycles with a valid 1+1+1 on the WIDTH=1 instance
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst_sum",  longint'(s1),    0);
            check("rst_cout", longint'(co1),   0);
            check("rst_vld",  longint'(ov_1v), 0);
            check("rst_w8_zero", longint'(z8), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_sum",  longint'(s1),    1);
        check("rel_cout", longint'(co1),   1);
        check("rel_vld",  longint'(ov_1v), 1);

        // WIDTH=1 exhaustive, one combination per cycle
        {a1, b1, c1} = 3'd0;
        for (int i = 0; i < 8; i++) begin
            {a1, b1, c1} = 3'(i);
            @(negedge clk);
            check($sformatf("exh%0d", i), longint'({co1, s1}), longint'(exp_tbl[i]));
        end
        v1 = 1'b0; a1 = 1'bx; b1 = 1'bx; c1 = 1'bx;

        // WIDTH=8 boundary cases
        v8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0;
        @(negedge clk);
        check("wrap_sum",  longint'(s8),  8'h00);
        check("wrap_cout", longint'(co8), 1);
        check("wrap_zero", longint'(z8),  1);
        check("wrap_ovf",  longint'(ov8), 0);
        a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0;
        @(negedge clk);
        check("sovf_sum",  longint'(s8),  8'h80);
        check("sovf_cout", longint'(co8), 0);
        check("sovf_ovf",  longint'(ov8), 1);
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        @(negedge clk);
        check("max_sum",  longint'(s8),  8'hFF);
        check("max_cout", longint'(co8), 1);
        check("max_ovf",  longint'(ov8), 0);
        check("max_zero", longint'(z8),  0);
        a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
        @(negedge clk);
        check("zz_zero", longint'(z8), 1);

        // hold: valid 3+4, then idle with junk and unknown operands
        a8 = 8'd3; b8 = 8'd4; c8 = 1'b0;
        @(negedge clk);
        check("hold_sum0", longint'(s8),    7);
        check("hold_vld0", longint'(ov_8v), 1);
        v8 = 1'b0; a8 = 8'hAA; b8 = 8'hxx; c8 = 1'bx;
        @(negedge clk);
        check("hold_vld1", longint'(ov_8v), 0);
        check("hold_sum1", longint'(s8),    7);
        @(negedge clk);
        check("hold_sum2", longint'(s8),    7);

        // WIDTH=16 back-to-back random
        v16 = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a16 = 16'($urandom_range(0, 16'hFFFF));
            b16 = 16'($urandom_range(0, 16'hFFFF));
            c16 = 1'($urandom_range(0, 1));
            if (i == 500) begin
                a16 = 16'hFFFF; b16 = 16'hFFFF; c16 = 1'b1;
            end
            @(negedge clk);
        end
        v16 = 1'b0;

        // reset mid-stream discards the op captured at the reset edge
        v8 = 1'b1; a8 = 8'd10; b8 = 8'd20; c8 = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_sum", longint'(s8),    0);
        check("mid_rst_vld", longint'(ov_8v), 0);
        rst_n = 1'b1; a8 = 8'd5; b8 = 8'd6; c8 = 1'b1;
        @(negedge clk);
        check("post_rst_sum", longint'(s8),    12);
        check("post_rst_vld", longint'(ov_8v), 1);
        v8 = 1'b0;
        repeat (2) @(negedge clk);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
